// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive frame sequencer.
// Holds the sequencer state encoding and Ethernet framing constants.
package eth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_DROP
    } state_t;

    localparam logic [7:0]  ETH_PREAMBLE     = 8'h55;
    localparam logic [7:0]  ETH_SFD          = 8'hD5;
    localparam int          ETH_HDR_LEN      = 14;
    localparam int          ETH_FCS_LEN      = 4;
    localparam logic [15:0] ETH_LEN_TYPE_MAX = 16'd1500;

endpackage

// File: rtl/eth_rx_delay4.sv
// Four-byte delay line for the receive path; last four bytes are the FCS.
// Ports: clk, rst (sync, high), clr, push, din -> dout (oldest byte),
//        full (four bytes held), fcs ({b3,b2,b1,b0}, b0 received first).
module eth_rx_delay4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic [31:0] fcs
);

    logic [31:0] sr;
    logic [2:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr  <= 32'h0;
            cnt <= 3'd0;
        end else if (push) begin
            sr <= {sr[23:0], din};
            if (cnt != 3'd4) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign dout = sr[31:24];
    assign full = (cnt == 3'd4);
    // Oldest byte is the first FCS byte, which is the CRC's low byte.
    assign fcs  = {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet receive frame sequencer: preamble/SFD strip, header capture,
// payload streaming, FCS isolation via eth_rx_delay4, crc32 control, status.
// Ports: clk, rst (sync, high), rx_data/rx_valid from the MAC, station_mac,
//        crc_value from crc32; crc_init/crc_en/crc_data to crc32;
//        pl_data/pl_valid payload; ethertype; frame_done/frame_ok/err_crc/
//        err_len/addr_miss status.
// Optional macro ETH_RX_ADDR_FILTER_EN enables destination address filtering.
module eth_rx_frame_ctrl
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD  = 1500,
    parameter int MIN_PAYLOAD  = 46,
    parameter int PREAMBLE_MIN = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [47:0] station_mac,
    input  logic [31:0] crc_value,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic [15:0] ethertype,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic        addr_miss
);

    localparam int OVH = ETH_HDR_LEN + ETH_FCS_LEN;
    localparam int NW  = $clog2(OVH + MAX_PAYLOAD + 2);

    // n counts bytes after SFD; the byte leaving the line is number n-3.
    localparam logic [NW-1:0] N_MIN     = NW'(OVH + MIN_PAYLOAD);
    localparam logic [NW-1:0] N_OVF     = NW'(OVH + MAX_PAYLOAD);
    localparam logic [NW-1:0] N_TYPE_HI = NW'(OVH - 2);
    localparam logic [NW-1:0] N_HDR_END = NW'(OVH - 1);
    localparam logic [NW-1:0] N_FULL    = NW'(ETH_FCS_LEN);
    localparam logic [3:0]    PRE_MIN   = 4'(PREAMBLE_MIN);

    state_t        state, state_nx;
    logic [3:0]    pcnt;
    logic [NW-1:0] n;
    logic          ovf;
    logic          in_frame, ovf_hit, push, full, pass;
    logic [7:0]    dout;
    logic [31:0]   fcs;
    logic [15:0]   pl_len;
    logic          len_short;

    eth_rx_delay4 u_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_init),
        .push (push),
        .din  (rx_data),
        .dout (dout),
        .full (full),
        .fcs  (fcs)
    );

    assign in_frame = (state == S_HEADER) || (state == S_PAYLOAD);
    assign ovf_hit  = in_frame && rx_valid && (n == N_OVF);
    assign push     = in_frame && rx_valid && !ovf_hit && !rst;

    assign crc_init = !rst && (state == S_PREAMBLE) && rx_valid &&
                      (rx_data == ETH_SFD) && (pcnt >= PRE_MIN);
    assign crc_en   = push && full;
    assign crc_data = crc_en ? dout : 8'h0;
    assign pl_valid = crc_en && (state == S_PAYLOAD) && pass;
    assign pl_data  = pl_valid ? dout : 8'h0;

    assign frame_done = !rst && (state == S_DONE);
    assign frame_ok   = frame_done && !err_len && !err_crc && !addr_miss;

    // Bytes still in the line at the end are FCS, not payload.
    assign pl_len    = 16'(n) - 16'(OVH);
    assign len_short = (ethertype <= ETH_LEN_TYPE_MAX) &&
                       (pl_len < ethertype);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    state_nx = (rx_data == ETH_PREAMBLE) ? S_PREAMBLE
                                                         : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_valid) begin
                    state_nx = S_IDLE;
                end else if (rx_data == ETH_SFD && pcnt >= PRE_MIN) begin
                    state_nx = S_HEADER;
                end else if (rx_data != ETH_PREAMBLE) begin
                    state_nx = S_DROP;
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (!rx_valid) begin
                    state_nx = S_CHECK;
                end else if (ovf_hit) begin
                    state_nx = S_DROP;
                end else if (state == S_HEADER && n == N_HDR_END) begin
                    state_nx = S_PAYLOAD;
                end
            end
            S_CHECK: state_nx = S_DONE;
            S_DONE:  state_nx = rx_valid ? S_DROP : S_IDLE;
            S_DROP: begin
                if (!rx_valid) begin
                    state_nx = ovf ? S_DONE : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pcnt      <= 4'd0;
            n         <= '0;
            ovf       <= 1'b0;
            ethertype <= 16'h0;
            err_crc   <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) begin
                pcnt <= 4'd1;
            end else if (state == S_PREAMBLE && rx_valid &&
                         rx_data == ETH_PREAMBLE && pcnt != 4'hF) begin
                pcnt <= pcnt + 4'd1;
            end
            if (crc_init) begin
                n         <= '0;
                ovf       <= 1'b0;
                ethertype <= 16'h0;
                err_crc   <= 1'b0;
                err_len   <= 1'b0;
            end
            if (push) begin
                n <= n + 1'b1;
                if (n == N_TYPE_HI) ethertype[15:8] <= dout;
                if (n == N_HDR_END) ethertype[7:0]  <= dout;
            end
            if (ovf_hit) begin
                ovf     <= 1'b1;
                err_len <= 1'b1;
            end
            if (in_frame && !rx_valid) begin
                err_len <= (n < N_MIN) || len_short;
            end
            // Runts shorter than the line carry no FCS to check.
            if (state == S_CHECK) begin
                err_crc <= (n >= N_FULL) && (crc_value != fcs);
            end
            if (state == S_DROP && !rx_valid) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef ETH_RX_ADDR_FILTER_EN
    logic        da_ne, da_nf, da_mc, miss_q;
    logic [2:0]  da_idx;
    logic [47:0] mac_sh;

    assign da_idx = 3'(n - NW'(4));
    assign mac_sh = station_mac << {da_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            da_ne  <= 1'b0;
            da_nf  <= 1'b0;
            da_mc  <= 1'b0;
            miss_q <= 1'b0;
        end else if (crc_init) begin
            da_ne  <= 1'b0;
            da_nf  <= 1'b0;
            da_mc  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            if (crc_en && state == S_HEADER && n < NW'(10)) begin
                if (dout != mac_sh[47:40]) da_ne <= 1'b1;
                if (dout != 8'hFF)         da_nf <= 1'b1;
                if (da_idx == 3'd0)        da_mc <= dout[0];
            end
            if (state == S_HEADER && state_nx == S_PAYLOAD) begin
                miss_q <= da_ne && da_nf && !da_mc;
            end
        end
    end

    assign addr_miss = miss_q;
    assign pass      = !miss_q;
`else
    logic unused_mac;
    assign unused_mac = ^station_mac;
    assign addr_miss  = 1'b0;
    assign pass       = 1'b1;
`endif

endmodule
